// File: rtl/lcd_bus_reader.sv
// Read-side controller for an HD44780-compatible character LCD bus.
// Issues RS/RW/EN read cycles to fetch busy flag + address counter, polls
// until the panel is ready, or sets the DDRAM address with a write cycle and
// then reads one character back. All outputs are registered.
module lcd_bus_reader #(
  parameter int unsigned ADDRESS_SETUP_INTERVAL = 4,
  parameter int unsigned ENABLE_INTERVAL        = 30,
  parameter int unsigned HOLD_INTERVAL          = 4,
  parameter int unsigned PROCESS_INTERVAL       = 22000,
  parameter int unsigned POLL_TIMEOUT           = 1500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       START,
  input  logic [1:0] MODE,
  input  logic [7:0] ADDRESS,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT,
  output logic [7:0] RESULT,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HIGH,
    HOLD,
    WAIT_PROC,
    FINISH
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] poll_cnt, poll_cnt_n;
  logic [1:0]  mode_q, mode_n;
  logic [6:0]  addr_q, addr_n;
  logic        write_phase, write_phase_n;
  logic        timeout_flag, timeout_flag_n;
  logic        busy_n, done_n, timeout_n;
  logic [7:0]  result_n, data_out_n;
  logic        oe_n, rs_n, rw_n, en_n;

  // State and registered outputs; reset drops the strobe and releases the bus at once
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      poll_cnt     <= '0;
      mode_q       <= '0;
      addr_q       <= '0;
      write_phase  <= 1'b0;
      timeout_flag <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      TIMEOUT      <= 1'b0;
      RESULT       <= '0;
      LCD_DATA_OUT <= '0;
      LCD_DATA_OE  <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_RW       <= 1'b1;
      LCD_EN       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      poll_cnt     <= poll_cnt_n;
      mode_q       <= mode_n;
      addr_q       <= addr_n;
      write_phase  <= write_phase_n;
      timeout_flag <= timeout_flag_n;
      BUSY         <= busy_n;
      DONE         <= done_n;
      TIMEOUT      <= timeout_n;
      RESULT       <= result_n;
      LCD_DATA_OUT <= data_out_n;
      LCD_DATA_OE  <= oe_n;
      LCD_RS       <= rs_n;
      LCD_RW       <= rw_n;
      LCD_EN       <= en_n;
    end
  end

  // Next-state and next-output logic; every bus phase is timed by the shared interval counter
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    mode_n         = mode_q;
    addr_n         = addr_q;
    write_phase_n  = write_phase;
    timeout_flag_n = timeout_flag;
    busy_n         = BUSY;
    done_n         = 1'b0;
    timeout_n      = TIMEOUT;
    result_n       = RESULT;
    data_out_n     = LCD_DATA_OUT;
    oe_n           = LCD_DATA_OE;
    rs_n           = LCD_RS;
    rw_n           = LCD_RW;
    en_n           = LCD_EN;
    poll_cnt_n     = poll_cnt;
    if (BUSY && !(&poll_cnt)) begin
      poll_cnt_n = poll_cnt + 32'd1;
    end

    case (state)
      IDLE: begin
        if (START) begin
          mode_n         = MODE;
          addr_n         = ADDRESS[6:0];
          busy_n         = 1'b1;
          poll_cnt_n     = '0;
          cnt_n          = '0;
          timeout_flag_n = 1'b0;
          state_n        = SETUP;
          en_n           = 1'b0;
          rs_n           = 1'b0;
          if (MODE == 2'd2) begin
            write_phase_n = 1'b1;
            oe_n          = 1'b1;
            rw_n          = 1'b0;
            data_out_n    = {1'b1, ADDRESS[6:0]};
          end else begin
            write_phase_n = 1'b0;
            oe_n          = 1'b0;
            rw_n          = 1'b1;
            data_out_n    = '0;
          end
        end
      end

      SETUP: begin
        if (cnt == ADDRESS_SETUP_INTERVAL - 1) begin
          cnt_n   = '0;
          state_n = EN_HIGH;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      EN_HIGH: begin
        if (cnt == ENABLE_INTERVAL - 1) begin
          cnt_n   = '0;
          state_n = HOLD;
          en_n    = 1'b0;
          if (!write_phase) begin
            result_n = LCD_DATA_IN;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      HOLD: begin
        if (cnt == HOLD_INTERVAL - 1) begin
          cnt_n = '0;
          if (write_phase) begin
            state_n       = WAIT_PROC;
            write_phase_n = 1'b0;
            oe_n          = 1'b0;
            rw_n          = 1'b1;
            data_out_n    = '0;
          end else if ((mode_q == 2'd1) && RESULT[7] && (poll_cnt < POLL_TIMEOUT)) begin
            state_n = SETUP;
          end else begin
            timeout_flag_n = (mode_q == 2'd1) && RESULT[7];
            state_n        = FINISH;
            rs_n           = 1'b0;
            rw_n           = 1'b1;
            oe_n           = 1'b0;
            en_n           = 1'b0;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      WAIT_PROC: begin
        if (cnt == PROCESS_INTERVAL - 1) begin
          cnt_n   = '0;
          state_n = SETUP;
          rs_n    = 1'b1;
          rw_n    = 1'b1;
          oe_n    = 1'b0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      FINISH: begin
        state_n   = IDLE;
        busy_n    = 1'b0;
        done_n    = 1'b1;
        timeout_n = timeout_flag;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: directed operations, a simple panel
// model on the data bus, and a scoreboard of expected RESULT/TIMEOUT/latency.
module tb_lcd_bus_reader;

  localparam int S = 2;
  localparam int E = 4;
  localparam int H = 2;
  localparam int P = 10;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       START = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [7:0] ADDRESS = 8'd0;
  logic       BUSY, DONE, TIMEOUT;
  logic [7:0] RESULT;
  logic [7:0] LCD_DATA_IN;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE, LCD_RS, LCD_RW, LCD_EN;

  typedef struct {
    logic [7:0] res;
    logic       to;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  int         rise_q[$];
  logic [10:0] strobe_q[$];

  int   cyc = 0;
  int   rises = 0;
  int   en_high = 0;
  int   oe_cycles = 0;
  int   done_count = 0;
  int   busy_rise = 0;
  logic en_prev = 1'b0;
  logic busy_prev = 1'b0;

  int   rise_base = 0;
  int   n_first = 0;
  logic [7:0] first_val = 8'h00;
  logic [7:0] later_val = 8'h00;

  int   checks = 0;
  int   errors = 0;

  lcd_bus_reader #(
    .ADDRESS_SETUP_INTERVAL(S),
    .ENABLE_INTERVAL(E),
    .HOLD_INTERVAL(H),
    .PROCESS_INTERVAL(P),
    .POLL_TIMEOUT(100)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .START(START),
    .MODE(MODE),
    .ADDRESS(ADDRESS),
    .BUSY(BUSY),
    .DONE(DONE),
    .TIMEOUT(TIMEOUT),
    .RESULT(RESULT),
    .LCD_DATA_IN(LCD_DATA_IN),
    .LCD_DATA_OUT(LCD_DATA_OUT),
    .LCD_DATA_OE(LCD_DATA_OE),
    .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Cycle counter
  always @(posedge i_clk) cyc <= cyc + 1;

  // Panel model: the first n_first strobes of an operation return first_val
  assign LCD_DATA_IN = ((rises - rise_base) <= n_first) ? first_val : later_val;

  // Bus monitor, sampled on the inactive edge
  always @(negedge i_clk) begin
    if (LCD_EN && !en_prev) begin
      rise_q.push_back(cyc);
      strobe_q.push_back({LCD_DATA_OUT, LCD_DATA_OE, LCD_RS, LCD_RW});
      rises = rises + 1;
    end
    if (LCD_EN) en_high = en_high + 1;
    if (LCD_DATA_OE) oe_cycles = oe_cycles + 1;
    if (DONE) done_count = done_count + 1;
    if (BUSY && !busy_prev) busy_rise = cyc;
    en_prev   = LCD_EN;
    busy_prev = BUSY;
  end

  // Watchdog
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setPanel(input int n, input logic [7:0] fv, input logic [7:0] lv);
    rise_base = rises;
    n_first   = n;
    first_val = fv;
    later_val = lv;
  endtask

  // Issues one operation, optionally pulses START again while busy, and
  // compares the DONE-time outputs against the scoreboard entry.
  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic [7:0] a,
                               input logic [7:0] exp_res, input logic exp_to, input int exp_lat,
                               input int glitch);
    int   start_cyc;
    exp_t item;
    sb_q.push_back('{exp_res, exp_to, exp_lat});
    @(negedge i_clk);
    MODE      = m;
    ADDRESS   = a;
    START     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge i_clk);
    START = 1'b0;
    for (int i = 0; i < 400 && !DONE; i++) begin
      if (i == glitch) begin
        START = 1'b1;
        MODE  = 2'd2;
      end else if (i == glitch + 1) begin
        START = 1'b0;
      end
      @(negedge i_clk);
    end
    START = 1'b0;
    item = sb_q.pop_front();
    checkOutput({tag, "_done_seen"}, 32'(DONE), 32'd1);
    if (DONE) begin
      checkOutput({tag, "_result"},  32'(RESULT),  32'(item.res));
      checkOutput({tag, "_timeout"}, 32'(TIMEOUT), 32'(item.to));
      checkOutput({tag, "_latency"}, 32'(cyc - start_cyc), 32'(item.lat));
      checkOutput({tag, "_busy_low"}, 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    int b_rise, b_high, b_oe, b_done;

    // Reset values
    #12;
    checkOutput("rst_busy",  32'(BUSY), 32'd0);
    checkOutput("rst_done",  32'(DONE), 32'd0);
    checkOutput("rst_to",    32'(TIMEOUT), 32'd0);
    checkOutput("rst_result", 32'(RESULT), 32'd0);
    checkOutput("rst_bus", 32'({LCD_DATA_OUT, LCD_DATA_OE, LCD_RS, LCD_RW, LCD_EN}),
                32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    // MODE 0 status read
    $display("[TB] mode 0 status read");
    setPanel(0, 8'h25, 8'h25);
    b_rise = rise_q.size();
    b_high = en_high;
    b_oe   = oe_cycles;
    applyStimulus("m0", 2'd0, 8'h00, 8'h25, 1'b0, S + E + H + 1, -1);
    checkOutput("m0_strobes", 32'(rise_q.size() - b_rise), 32'd1);
    checkOutput("m0_en_width", 32'(en_high - b_high), 32'(E));
    checkOutput("m0_en_delay", 32'(rise_q[b_rise] - busy_rise), 32'(S));
    checkOutput("m0_oe_never", 32'(oe_cycles - b_oe), 32'd0);

    // MODE 2 DDRAM read
    $display("[TB] mode 2 character read");
    setPanel(0, 8'h41, 8'h41);
    b_rise = rise_q.size();
    b_oe   = oe_cycles;
    applyStimulus("m2", 2'd2, 8'h45, 8'h41, 1'b0, 2 * (S + E + H) + P + 1, -1);
    checkOutput("m2_strobes", 32'(rise_q.size() - b_rise), 32'd2);
    checkOutput("m2_wr_strobe", 32'(strobe_q[b_rise]), 32'({8'hC5, 1'b1, 1'b0, 1'b0}));
    checkOutput("m2_rd_strobe", 32'(strobe_q[b_rise + 1][2:0]), 32'({1'b0, 1'b1, 1'b1}));
    checkOutput("m2_gap", 32'(rise_q[b_rise + 1] - rise_q[b_rise]), 32'(S + E + H + P));
    checkOutput("m2_oe_cycles", 32'(oe_cycles - b_oe), 32'(S + E + H));

    // MODE 1 poll that becomes ready on the fourth read
    $display("[TB] mode 1 poll until ready");
    setPanel(3, 8'h80, 8'h12);
    b_rise = rise_q.size();
    applyStimulus("m1", 2'd1, 8'h00, 8'h12, 1'b0, 4 * (S + E + H) + 1, -1);
    checkOutput("m1_strobes", 32'(rise_q.size() - b_rise), 32'd4);
    checkOutput("m1_spacing", 32'(rise_q[b_rise + 3] - rise_q[b_rise]), 32'(3 * (S + E + H)));

    // MODE 1 poll that expires: first iteration ending with counter >= 100 is the 13th
    $display("[TB] mode 1 poll timeout");
    setPanel(0, 8'h8A, 8'h8A);
    b_rise = rise_q.size();
    applyStimulus("m1to", 2'd1, 8'h00, 8'h8A, 1'b1, 13 * (S + E + H) + 1, -1);
    repeat (20) @(negedge i_clk);
    checkOutput("m1to_strobes", 32'(rise_q.size() - b_rise), 32'd13);

    // START pulsed while busy is ignored; START right after DONE is accepted
    $display("[TB] start while busy, then back-to-back start");
    setPanel(0, 8'h33, 8'h33);
    b_done = done_count;
    applyStimulus("ign", 2'd0, 8'h00, 8'h33, 1'b0, S + E + H + 1, 3);
    setPanel(0, 8'h5C, 8'h5C);
    applyStimulus("b2b", 2'd3, 8'h00, 8'h5C, 1'b0, S + E + H + 1, -1);
    repeat (40) @(negedge i_clk);
    checkOutput("ign_done_count", 32'(done_count - b_done), 32'd2);

    // Reset during the write strobe of a MODE 2 operation
    $display("[TB] reset while EN high");
    @(negedge i_clk);
    MODE    = 2'd2;
    ADDRESS = 8'h10;
    START   = 1'b1;
    @(negedge i_clk);
    START = 1'b0;
    for (int i = 0; i < 50 && !LCD_EN; i++) @(negedge i_clk);
    checkOutput("rst_en_seen", 32'(LCD_EN), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    checkOutput("mid_rst_en",   32'(LCD_EN), 32'd0);
    checkOutput("mid_rst_oe",   32'(LCD_DATA_OE), 32'd0);
    checkOutput("mid_rst_rw",   32'(LCD_RW), 32'd1);
    checkOutput("mid_rst_busy", 32'(BUSY), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    setPanel(0, 8'h07, 8'h07);
    applyStimulus("post_rst", 2'd0, 8'h00, 8'h07, 1'b0, S + E + H + 1, -1);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
